// File: rtl/cpu_state_unit_pkg.sv
// Shared types and widths for the nandgame CPU sequential core.
package cpu_pkg;

  localparam int CPU_W    = 16;
  localparam int RETIRE_W = 32;

  typedef logic [CPU_W-1:0]    word_t;
  typedef logic [RETIRE_W-1:0] retire_t;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    EXEC  = 2'd1,
    MEMWR = 2'd2
  } cpu_state_t;

endpackage

// File: rtl/cpu_state_unit_if.sv
// Fetch, control_unit and data-memory write signals of cpu_state_unit.
// CPU_RETIRE_CNT_EN adds the retired-instruction counter output.
interface cpu_state_unit_if;
  import cpu_pkg::*;

  word_t   imem_addr;
  logic    imem_valid;
  word_t   imem_data;
  word_t   instr;
  word_t   reg_a;
  word_t   reg_d;
  word_t   ctl_dat_r;
  logic    ctl_a;
  logic    ctl_d;
  logic    ctl_dref_a;
  logic    ctl_j;
  logic    dmem_wr_valid;
  logic    dmem_wr_ready;
  word_t   dmem_wr_addr;
  word_t   dmem_wr_data;
  logic    exec;
`ifdef CPU_RETIRE_CNT_EN
  retire_t retired;
`endif

  modport master (
`ifdef CPU_RETIRE_CNT_EN
    output retired,
`endif
    output imem_addr, input imem_valid, input imem_data,
    output instr, output reg_a, output reg_d,
    input ctl_dat_r, input ctl_a, input ctl_d, input ctl_dref_a, input ctl_j,
    output dmem_wr_valid, input dmem_wr_ready, output dmem_wr_addr, output dmem_wr_data,
    output exec
  );

  modport slave (
`ifdef CPU_RETIRE_CNT_EN
    input retired,
`endif
    input imem_addr, output imem_valid, output imem_data,
    input instr, input reg_a, input reg_d,
    output ctl_dat_r, output ctl_a, output ctl_d, output ctl_dref_a, output ctl_j,
    input dmem_wr_valid, output dmem_wr_ready, input dmem_wr_addr, input dmem_wr_data,
    input exec
  );

endinterface

// File: rtl/cpu_state_unit_pc_next.sv
// Next-PC select: jump to the pre-commit A value, else PC + 1 with 16-bit wrap.
module pc_next
  import cpu_pkg::*;
(
  input  word_t pc,
  input  word_t old_a,
  input  logic  jump,
  output word_t next_pc
);

  // jump target or sequential increment
  always_comb begin
    next_pc = pc;
    if (jump) begin
      next_pc = old_a;
    end else begin
      next_pc = pc + 16'd1;
    end
  end

endmodule

// File: rtl/cpu_state_unit.sv
// Sequential core of the nandgame CPU: A/D/PC/IR, fetch handshake, data-memory writes.
// Optional CPU_RETIRE_CNT_EN adds a 32-bit retired-instruction counter.
module cpu_state_unit
  import cpu_pkg::*;
#(
  parameter word_t RESET_PC = 16'h0000
)
(
  input logic             clk,
  input logic             rst,
  cpu_state_unit_if.master bus
);

  cpu_state_t state_r, next_state_s;
  word_t      pc_r, a_r, d_r, ir_r;
  word_t      wr_addr_r, wr_data_r;
  word_t      pc_next_s;
  logic       wr_valid_r, exec_r;
  logic       fetch_take_s, exec_s, wr_done_s;

  assign fetch_take_s = (state_r == FETCH) && bus.imem_valid;
  assign exec_s       = (state_r == EXEC);
  assign wr_done_s    = (state_r == MEMWR) && bus.dmem_wr_ready;

  // a_r here is the value before the EXEC edge, so jumps use old A
  pc_next u_pc_next (
    .pc      (pc_r),
    .old_a   (a_r),
    .jump    (bus.ctl_j),
    .next_pc (pc_next_s)
  );

  // next-state logic
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      FETCH: begin
        if (bus.imem_valid) begin
          next_state_s = EXEC;
        end else begin
          next_state_s = FETCH;
        end
      end
      EXEC: begin
        if (bus.ctl_dref_a) begin
          next_state_s = MEMWR;
        end else begin
          next_state_s = FETCH;
        end
      end
      MEMWR: begin
        if (bus.dmem_wr_ready) begin
          next_state_s = FETCH;
        end else begin
          next_state_s = MEMWR;
        end
      end
      default: next_state_s = FETCH;
    endcase
  end

  // state register and registered exec strobe
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= FETCH;
      exec_r  <= 1'b0;
    end else begin
      state_r <= next_state_s;
      exec_r  <= (next_state_s == EXEC);
    end
  end

  // instruction register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ir_r <= 16'h0000;
    end else if (fetch_take_s) begin
      ir_r <= bus.imem_data;
    end
  end

  // architectural registers commit in EXEC
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_r <= RESET_PC;
      a_r  <= 16'h0000;
      d_r  <= 16'h0000;
    end else if (exec_s) begin
      pc_r <= pc_next_s;
      if (bus.ctl_a) begin
        a_r <= bus.ctl_dat_r;
      end
      if (bus.ctl_d) begin
        d_r <= bus.ctl_dat_r;
      end
    end
  end

  // data-memory write request, held until accepted
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_valid_r <= 1'b0;
      wr_addr_r  <= 16'h0000;
      wr_data_r  <= 16'h0000;
    end else if (exec_s && bus.ctl_dref_a) begin
      wr_valid_r <= 1'b1;
      wr_addr_r  <= a_r;
      wr_data_r  <= bus.ctl_dat_r;
    end else if (wr_done_s) begin
      wr_valid_r <= 1'b0;
    end
  end

`ifdef CPU_RETIRE_CNT_EN
  retire_t retired_r;
  logic    retire_s;

  assign retire_s = (exec_s && !bus.ctl_dref_a) || wr_done_s;

  // one count per fully completed instruction
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      retired_r <= 32'd0;
    end else if (retire_s) begin
      retired_r <= retired_r + 32'd1;
    end
  end

  assign bus.retired = retired_r;
`endif

  assign bus.imem_addr     = pc_r;
  assign bus.instr         = ir_r;
  assign bus.reg_a         = a_r;
  assign bus.reg_d         = d_r;
  assign bus.dmem_wr_valid = wr_valid_r;
  assign bus.dmem_wr_addr  = wr_addr_r;
  assign bus.dmem_wr_data  = wr_data_r;
  assign bus.exec          = exec_r;

endmodule

// File: tb/tb_cpu_state_unit.sv
// Self-checking bench for cpu_state_unit: directed scenarios plus randomized
// instructions checked against an instruction-level reference model.
module tb_cpu_state_unit;
  import cpu_pkg::*;

  localparam logic [15:0] RST_PC = 16'h0010;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cpu_state_unit_if bus();

  cpu_state_unit #(.RESET_PC(RST_PC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_cmp = 0;
  int n_err = 0;

  logic [15:0] m_a, m_d, m_pc;
  logic [31:0] m_ret;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // signals the DUT must ignore in the current phase get random values
  task automatic noise_ctl;
    bus.ctl_a      = 1'($urandom);
    bus.ctl_d      = 1'($urandom);
    bus.ctl_dref_a = 1'($urandom);
    bus.ctl_j      = 1'($urandom);
    bus.ctl_dat_r  = 16'($urandom);
  endtask

  task automatic check_regs(input string tag);
    chk({tag, "_a"},    32'(bus.reg_a), 32'(m_a));
    chk({tag, "_d"},    32'(bus.reg_d), 32'(m_d));
    chk({tag, "_pc"},   32'(bus.imem_addr), 32'(m_pc));
`ifdef CPU_RETIRE_CNT_EN
    chk({tag, "_ret"},  bus.retired, m_ret);
`endif
  endtask

  task automatic model_reset;
    m_a = 16'h0000; m_d = 16'h0000; m_pc = RST_PC; m_ret = 32'd0;
  endtask

  // one whole instruction: gap cycles without imem_valid, fetch, execute, optional write
  task automatic do_instr(input int gap, input logic [15:0] w,
                          input logic ca, input logic cd, input logic cdr, input logic cj,
                          input logic [15:0] dat, input int rdy_low);
    logic [15:0] old_a;
    for (int i = 0; i < gap; i++) begin
      noise_ctl();
      bus.imem_valid    = 1'b0;
      bus.imem_data     = 16'($urandom);
      bus.dmem_wr_ready = 1'($urandom);
      step();
      chk("wait_exec", 32'(bus.exec), 32'd0);
      chk("wait_addr", 32'(bus.imem_addr), 32'(m_pc));
    end
    noise_ctl();
    bus.imem_valid = 1'b1;
    bus.imem_data  = w;
    step();
    chk("exec_hi",   32'(bus.exec), 32'd1);
    chk("exec_ir",   32'(bus.instr), 32'(w));
    chk("exec_a",    32'(bus.reg_a), 32'(m_a));
    chk("exec_d",    32'(bus.reg_d), 32'(m_d));
    chk("exec_wrv",  32'(bus.dmem_wr_valid), 32'd0);
    bus.ctl_a      = ca;
    bus.ctl_d      = cd;
    bus.ctl_dref_a = cdr;
    bus.ctl_j      = cj;
    bus.ctl_dat_r  = dat;
    bus.imem_valid = 1'($urandom);
    bus.imem_data  = 16'($urandom);
    bus.dmem_wr_ready = 1'($urandom);
    step();
    old_a = m_a;
    if (ca) m_a = dat;
    if (cd) m_d = dat;
    m_pc = cj ? old_a : m_pc + 16'd1;
    chk("exec_lo", 32'(bus.exec), 32'd0);
    if (cdr) begin
      for (int i = 0; i < rdy_low; i++) begin
        noise_ctl();
        bus.imem_valid    = 1'($urandom);
        bus.dmem_wr_ready = 1'b0;
        chk("wr_hold_v", 32'(bus.dmem_wr_valid), 32'd1);
        chk("wr_hold_a", 32'(bus.dmem_wr_addr), 32'(old_a));
        chk("wr_hold_d", 32'(bus.dmem_wr_data), 32'(dat));
        step();
        chk("wr_noexec", 32'(bus.exec), 32'd0);
      end
      noise_ctl();
      bus.dmem_wr_ready = 1'b1;
      chk("wr_hs_v", 32'(bus.dmem_wr_valid), 32'd1);
      chk("wr_hs_a", 32'(bus.dmem_wr_addr), 32'(old_a));
      chk("wr_hs_d", 32'(bus.dmem_wr_data), 32'(dat));
      step();
      chk("wr_done_v", 32'(bus.dmem_wr_valid), 32'd0);
      chk("wr_done_x", 32'(bus.exec), 32'd0);
    end else begin
      chk("nowr_v", 32'(bus.dmem_wr_valid), 32'd0);
    end
    m_ret = m_ret + 32'd1;
    bus.dmem_wr_ready = 1'b0;
    bus.imem_valid    = 1'b0;
    check_regs("post");
  endtask

  initial begin
    rst = 1'b1;
    bus.imem_valid = 1'b0; bus.imem_data = 16'h0000; bus.dmem_wr_ready = 1'b0;
    bus.ctl_a = 1'b0; bus.ctl_d = 1'b0; bus.ctl_dref_a = 1'b0; bus.ctl_j = 1'b0;
    bus.ctl_dat_r = 16'h0000;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_pc",   32'(bus.imem_addr), 32'h0010);
    chk("rst_ir",   32'(bus.instr), 32'd0);
    chk("rst_a",    32'(bus.reg_a), 32'd0);
    chk("rst_d",    32'(bus.reg_d), 32'd0);
    chk("rst_wrv",  32'(bus.dmem_wr_valid), 32'd0);
    chk("rst_wra",  32'(bus.dmem_wr_addr), 32'd0);
    chk("rst_wrd",  32'(bus.dmem_wr_data), 32'd0);
    chk("rst_exec", 32'(bus.exec), 32'd0);
    rst = 1'b0;

    do_instr(0, 16'hABCD, 1'b1, 1'b0, 1'b0, 1'b0, 16'h1234, 0);
    chk("t1_a",  32'(bus.reg_a), 32'h1234);
    chk("t1_pc", 32'(bus.imem_addr), 32'h0011);

    do_instr(0, 16'h0001, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0040, 0);
    do_instr(0, 16'h0002, 1'b1, 1'b0, 1'b1, 1'b0, 16'h00AA, 3);
    chk("t2_a", 32'(bus.reg_a), 32'h00AA);

    do_instr(0, 16'h0003, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0100, 0);
    do_instr(0, 16'h0004, 1'b1, 1'b0, 1'b0, 1'b1, 16'h0200, 0);
    chk("t3_pc", 32'(bus.imem_addr), 32'h0100);
    chk("t3_a",  32'(bus.reg_a), 32'h0200);

    do_instr(0, 16'h0005, 1'b1, 1'b0, 1'b0, 1'b0, 16'hFFFF, 0);
    do_instr(0, 16'h0006, 1'b0, 1'b1, 1'b0, 1'b1, 16'h7777, 0);
    chk("t4_pcff", 32'(bus.imem_addr), 32'hFFFF);
    do_instr(0, 16'h0007, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 0);
    chk("t4_wrap", 32'(bus.imem_addr), 32'h0000);

    do_instr(5, 16'h0008, 1'b0, 1'b1, 1'b0, 1'b0, 16'h5A5A, 0);

    // reset while a write is pending in MEMWR
    do_instr(0, 16'h0009, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0055, 0);
    bus.imem_valid = 1'b1; bus.imem_data = 16'h000A;
    step();
    bus.imem_valid = 1'b0;
    bus.ctl_a = 1'b0; bus.ctl_d = 1'b0; bus.ctl_j = 1'b0;
    bus.ctl_dref_a = 1'b1; bus.ctl_dat_r = 16'h0099; bus.dmem_wr_ready = 1'b0;
    step();
    step();
    chk("t6_pend", 32'(bus.dmem_wr_valid), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("t6_wrv",  32'(bus.dmem_wr_valid), 32'd0);
    chk("t6_pc",   32'(bus.imem_addr), 32'(RST_PC));
    chk("t6_a",    32'(bus.reg_a), 32'd0);
    chk("t6_ir",   32'(bus.instr), 32'd0);
    chk("t6_exec", 32'(bus.exec), 32'd0);
`ifdef CPU_RETIRE_CNT_EN
    chk("t6_ret",  bus.retired, 32'd0);
`endif
    #2 rst = 1'b0;
    model_reset();
    do_instr(0, 16'h000B, 1'b0, 1'b1, 1'b0, 1'b0, 16'h3C3C, 0);

    for (int k = 0; k < 80; k++) begin
      do_instr(int'($urandom_range(0, 3)), 16'($urandom),
               1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
               16'($urandom), int'($urandom_range(0, 3)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/cpu_state_unit.md
# cpu_state_unit

Sequential core of the nandgame CPU, downstream of `control_unit`. It holds the architectural registers A, D and PC. It fetches instructions over a valid handshake and presents the latched instruction and register values to `control_unit`. It then commits the returned `dat_r` / `a` / `d` / `dref_a` / `j` results and issues data-memory writes over a valid/ready handshake.

## Interface
Parameters:
- `RESET_PC`, default 16'h0000: PC value after reset.

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  reset; asynchronous, active-high.
- `imem_addr`  out  16  instruction fetch address (= PC).
- `imem_valid`  in  1  `imem_data` valid for `imem_addr` this cycle.
- `imem_data`  in  16  fetched instruction word.
- `instr`  out  16  latched instruction register (IR) to `control_unit`.
- `reg_a`  out  16  A register to `control_unit` `dat_a` and data-memory read address.
- `reg_d`  out  16  D register to `control_unit` `dat_d`.
- `ctl_dat_r`  in  16  result from `control_unit`.
- `ctl_a`, `ctl_d`, `ctl_dref_a`, `ctl_j`  in  1 each  destination/jump flags from `control_unit`.
- `dmem_wr_valid`  out  1  write request.
- `dmem_wr_ready`  in  1  memory accepts write this cycle.
- `dmem_wr_addr`  out  16  write address.
- `dmem_wr_data`  out  16  write data.
- `exec`  out  1  high in the cycle the current IR is evaluated and committed.

## Operation
- States: FETCH, EXEC, MEMWR. Reset state is FETCH.
- Reset values:
  - PC = `RESET_PC`; A = D = IR = 0.
  - `dmem_wr_valid` = 0, `dmem_wr_addr` = `dmem_wr_data` = 0, `exec` = 0.
- FETCH:
  - `imem_addr` = PC, held stable.
  - On `imem_valid`, IR <= `imem_data` and go to EXEC. Otherwise stay.
- EXEC, one cycle, `exec` = 1. Control inputs are sampled combinationally from `control_unit`.
  - `ctl_a` → A <= `ctl_dat_r`.
  - `ctl_d` → D <= `ctl_dat_r`.
  - `ctl_j` → PC <= old A; else PC <= PC + 1, 16-bit wrap (16'hFFFF → 16'h0000).
  - `ctl_dref_a` → latch `dmem_wr_addr` <= old A and `dmem_wr_data` <= `ctl_dat_r`, assert `dmem_wr_valid`, go to MEMWR. Else go to FETCH.
- MEMWR:
  - Hold `dmem_wr_valid`, `dmem_wr_addr` and `dmem_wr_data` stable until `dmem_wr_ready`.
  - On the handshake cycle, deassert `dmem_wr_valid` next cycle and go to FETCH.
  - A, D and PC are already committed.
- Old-A rule: the jump target and the write address always use A from before the EXEC edge, even when `ctl_a` is set in the same instruction.
- Any combination of `ctl_a`, `ctl_d`, `ctl_dref_a` and `ctl_j` may be active at once. All use the same `ctl_dat_r`.
- Reset mid-operation:
  - Asserting `rst` in any state returns all registers to reset values immediately, asynchronously.
  - A pending write is dropped: `dmem_wr_valid` falls with `rst`.

## Timing
- Minimum 2 cycles per instruction (FETCH, EXEC) with `imem_valid` tied high.
- Instructions with `ctl_dref_a` take 3 + (cycles `dmem_wr_ready` is low).
- `dmem_wr_valid` rises on the edge that ends EXEC and does not drop before handshake completion.
- `imem_data` is ignored outside FETCH.
- `exec` is registered from state: high for exactly one cycle per instruction.

## Configuration
- `CPU_RETIRE_CNT_EN`
  - Defined: adds output `retired` (32 bits).
    - Reset value 0.
    - Increments by 1 on each EXEC→FETCH transition and each MEMWR handshake cycle, i.e. once per fully completed instruction. Wraps at 2^32.
  - Undefined: no port, no counter logic.

## Structure
- Shared package `cpu_pkg`:
  - state enum `cpu_state_t` {FETCH, EXEC, MEMWR};
  - `CPU_W` = 16;
  - `RETIRE_W` = 32.
- One natural sub-module, `pc_next`: combinational next-PC select (jump to old A vs PC + 1 with wrap). It is instantiated once.

## Test plan
- Reset with `RESET_PC` = 16'h0010, `imem_valid` = 1, IR result `ctl_a` = 1, `ctl_dat_r` = 16'h1234 → after one FETCH/EXEC: A = 16'h1234, D = 0, PC = 16'h0011, `exec` pulsed once.
- A = 16'h0040, `ctl_dref_a` = 1, `ctl_a` = 1, `ctl_dat_r` = 16'h00AA, `dmem_wr_ready` low 3 cycles → `dmem_wr_valid` held 4 cycles with addr 16'h0040, data 16'h00AA; A = 16'h00AA; next fetch 6 cycles after first FETCH edge.
- A = 16'h0100, `ctl_j` = 1, `ctl_a` = 1, `ctl_dat_r` = 16'h0200 → PC = 16'h0100 (old A), A = 16'h0200.
- PC = 16'hFFFF, no jump → PC wraps to 16'h0000, `imem_addr` = 16'h0000 next FETCH.
- `imem_valid` low 5 cycles in FETCH → no state change, `exec` stays 0, `imem_addr` stable.
- `rst` asserted during MEMWR with `dmem_wr_ready` = 0 → `dmem_wr_valid` = 0 immediately, PC = `RESET_PC`, state FETCH; with `CPU_RETIRE_CNT_EN`, `retired` = 0.
